// File: rtl/rp_offset_seq_pkg.sv
// Shared constants and helpers for the RP head-offset sequencer.
// Holds function codes, state encodings and the offset-field/position arithmetic.
package rp_offset_seq_pkg;

   localparam logic [4:0] FUN_OFFSET = 5'o06;
   localparam logic [4:0] FUN_RTC    = 5'o07;

   localparam int TMR_W = 16;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_STEP   = 3'd2;
   localparam logic [2:0] ST_SETTLE = 3'd3;
   localparam logic [2:0] ST_DONE   = 3'd4;

   // OFD selects the sign, OFS is the magnitude.
   function automatic logic signed [7:0] ofs_to_target(input logic ofd, input logic [6:0] ofs);
      logic signed [7:0] mag;
      mag = $signed({1'b0, ofs});
      return ofd ? -mag : mag;
   endfunction

   // One unit toward target, clamped to +/-127 so the position never wraps.
   function automatic logic signed [7:0] step_toward(input logic signed [7:0] pos,
                                                     input logic signed [7:0] target);
      if (pos < target)
         return (pos == 8'sd127) ? pos : pos + 8'sd1;
      else if (pos > target)
         return (pos == -8'sd127) ? pos : pos - 8'sd1;
      else
         return pos;
   endfunction

endpackage

// File: rtl/rp_offset_tmr.sv
// Loadable down-counter shared by the step and settle delays.
// zero strobes for the single cycle in which the count reads one.
module rp_offset_tmr
   import rp_offset_seq_pkg::*;
#(
   parameter int W = TMR_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] val,
   output logic         zero
);

   logic [W-1:0] cnt;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (load)
         cnt <= val;
      else if (cnt != '0)
         cnt <= cnt - W'(1);
   end

   assign zero = (cnt == W'(1));

endmodule

// File: rtl/rp_offset_seq.sv
// RPxx head-offset sequencer: steps the simulated head toward an OFFSET/RTC target.
// Build option RPOFS_SETTLE_EN adds a settle delay between the last step and DONE.
module rp_offset_seq
   import rp_offset_seq_pkg::*;
#(
   parameter int STEP_CYC   = 50,
   parameter int SETTLE_CYC = 500,
   parameter int MAXOFS     = 127
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic        rpGO,
   input  logic [4:0]  rpFUN,
   input  logic [15:0] rpOF,
   output logic        ofsBUSY,
   output logic        ofsDONE,
   output logic        ofsERR,
   output logic        ofsCENTER,
   output logic [7:0]  ofsPOS
);

   logic [2:0]        state;
   logic signed [7:0] pos;
   logic signed [7:0] target;
   logic              err;
   logic signed [7:0] next_pos;
   logic              go_ok;
   logic              illegal;
   logic              tmr_load;
   logic [TMR_W-1:0]  tmr_val;
   logic              tmr_zero;
   logic              unused_of;

   assign go_ok     = rpGO && ((rpFUN == FUN_OFFSET) || (rpFUN == FUN_RTC));
   assign illegal   = (rpFUN == FUN_OFFSET) && (int'(rpOF[6:0]) > MAXOFS);
   assign next_pos  = step_toward(pos, target);
   assign unused_of = ^rpOF[15:8];

`ifdef RPOFS_SETTLE_EN
   localparam logic [2:0] ST_AFTER_STEP = ST_SETTLE;
`else
   localparam logic [2:0] ST_AFTER_STEP = ST_DONE;
   logic unused_settle;
   assign unused_settle = (SETTLE_CYC == 0);
`endif

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      tmr_load = 1'b0;
      tmr_val  = TMR_W'(STEP_CYC);
      if (clr || state == ST_START || (state == ST_STEP && tmr_zero))
         tmr_load = 1'b1;
`ifdef RPOFS_SETTLE_EN
      if ((state == ST_START && pos == target) || (state == ST_STEP && next_pos == target))
         tmr_val = TMR_W'(SETTLE_CYC);
`endif
   end

   rp_offset_tmr #(.W(TMR_W)) u_tmr (
      .clk  (clk),
      .rst  (rst),
      .load (tmr_load),
      .val  (tmr_val),
      .zero (tmr_zero)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= ST_IDLE;
         pos    <= '0;
         target <= '0;
         err    <= 1'b0;
      end else if (clr) begin
         state <= ST_IDLE;
         err   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: if (go_ok) begin
               target <= (rpFUN == FUN_RTC) ? 8'sd0 : ofs_to_target(rpOF[7], rpOF[6:0]);
               err    <= illegal;
               state  <= ST_START;
            end
            // Decision cycle: illegal and already-there requests skip stepping.
            ST_START: begin
               if (err)
                  state <= ST_DONE;
               else if (pos == target)
                  state <= ST_AFTER_STEP;
               else
                  state <= ST_STEP;
            end
            ST_STEP: if (tmr_zero) begin
               pos <= next_pos;
               if (next_pos == target)
                  state <= ST_AFTER_STEP;
            end
`ifdef RPOFS_SETTLE_EN
            ST_SETTLE: if (tmr_zero) state <= ST_DONE;
`endif
            ST_DONE: begin
               state <= ST_IDLE;
               err   <= 1'b0;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign ofsBUSY   = (state != ST_IDLE);
   assign ofsDONE   = (state == ST_DONE);
   assign ofsERR    = (state == ST_DONE) && err;
   assign ofsCENTER = (pos == 8'sd0);
   assign ofsPOS    = pos;

endmodule

// File: tb/tb_rp_offset_seq.sv
// Directed self-checking bench for rp_offset_seq (STEP_CYC=2, SETTLE_CYC=4, MAXOFS=10).
// Expected latencies follow the RPOFS_SETTLE_EN setting of the build.
module tb_rp_offset_seq;

   localparam logic [4:0] OFFSET = 5'o06;
   localparam logic [4:0] RTC    = 5'o07;
   localparam int STEP   = 2;
`ifdef RPOFS_SETTLE_EN
   localparam int SETTLE = 4;
`else
   localparam int SETTLE = 0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        clr;
   logic        rpGO;
   logic [4:0]  rpFUN;
   logic [15:0] rpOF;
   logic        ofsBUSY, ofsDONE, ofsERR, ofsCENTER;
   logic [7:0]  ofsPOS;

   int n_vec  = 0;
   int n_miss = 0;

   rp_offset_seq #(.STEP_CYC(2), .SETTLE_CYC(4), .MAXOFS(10)) dut (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .rpGO      (rpGO),
      .rpFUN     (rpFUN),
      .rpOF      (rpOF),
      .ofsBUSY   (ofsBUSY),
      .ofsDONE   (ofsDONE),
      .ofsERR    (ofsERR),
      .ofsCENTER (ofsCENTER),
      .ofsPOS    (ofsPOS)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Inputs change and outputs are sampled 1 ns after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic go(input logic [4:0] fun, input logic [15:0] of);
      rpFUN = fun;
      rpOF  = of;
      rpGO  = 1'b1;
      tick();
      rpGO  = 1'b0;
   endtask

   // k counts cycles after the rpGO cycle; pos is probed at k=4 and k=6.
   task automatic run_seq(input string tag, input logic [4:0] fun, input logic [15:0] of,
                          input logic [7:0] p4, input logic [7:0] p6, input logic [7:0] fin,
                          input int lat, input logic exp_err, input bit inject);
      int   first;
      int   nd;
      logic err_at;
      first  = 0;
      nd     = 0;
      err_at = 1'b0;
      check({tag, ".idle"}, 16'(ofsBUSY), 16'd0);
      go(fun, of);
      for (int k = 1; k <= lat + 3; k++) begin
         if (k == 1) check({tag, ".busy"}, 16'(ofsBUSY), 16'd1);
         if (k == 4 && lat >= 4) check({tag, ".pos4"}, 16'(ofsPOS), 16'(p4));
         if (k == 6 && lat >= 6) check({tag, ".pos6"}, 16'(ofsPOS), 16'(p6));
         if (ofsDONE) begin
            nd++;
            if (first == 0) begin
               first  = k;
               err_at = ofsERR;
            end
         end
         if (inject && k == 3) begin
            rpFUN = OFFSET;
            rpOF  = 16'o000212;
            rpGO  = 1'b1;
         end
         if (inject && k == 4) rpGO = 1'b0;
         tick();
      end
      check({tag, ".lat"},    16'(first),     16'(lat));
      check({tag, ".ndone"},  16'(nd),        16'd1);
      check({tag, ".err"},    16'(err_at),    16'(exp_err));
      check({tag, ".pos"},    16'(ofsPOS),    16'(fin));
      check({tag, ".center"}, 16'(ofsCENTER), 16'(fin == 8'h00));
      check({tag, ".busy0"},  16'(ofsBUSY),   16'd0);
   endtask

   initial begin
      int nd;
      rst   = 1'b1;
      clr   = 1'b0;
      rpGO  = 1'b0;
      rpFUN = 5'o00;
      rpOF  = 16'o0;
      #12;
      check("rst.pos",    16'(ofsPOS),    16'd0);
      check("rst.busy",   16'(ofsBUSY),   16'd0);
      check("rst.done",   16'(ofsDONE),   16'd0);
      check("rst.err",    16'(ofsERR),    16'd0);
      check("rst.center", 16'(ofsCENTER), 16'd1);
      rst = 1'b0;
      tick();

      run_seq("ofs3",  OFFSET, 16'o000003, 8'd1,  8'd2,  8'd3,  1 + 3*STEP + SETTLE + 1, 1'b0, 1'b0);
      run_seq("rtc3",  RTC,    16'o000003, 8'd2,  8'd1,  8'd0,  1 + 3*STEP + SETTLE + 1, 1'b0, 1'b0);
      run_seq("neg2",  OFFSET, 16'o000202, 8'hFF, 8'hFE, 8'hFE, 1 + 2*STEP + SETTLE + 1, 1'b0, 1'b0);
      run_seq("illeg", OFFSET, 16'o000013, 8'h00, 8'h00, 8'hFE, 2,                       1'b1, 1'b0);
      run_seq("rtcn",  RTC,    16'o000000, 8'hFF, 8'h00, 8'h00, 1 + 2*STEP + SETTLE + 1, 1'b0, 1'b0);

      // Abort after the first step, then clr beating a simultaneous rpGO.
      go(OFFSET, 16'o000003);
      tick(); tick(); tick();
      check("clr.pre", 16'(ofsPOS), 16'd1);
      clr = 1'b1;
      tick();
      check("clr.busy", 16'(ofsBUSY), 16'd0);
      check("clr.pos",  16'(ofsPOS),  16'd1);
      rpGO = 1'b1;
      tick();
      rpGO = 1'b0;
      clr  = 1'b0;
      check("clr.go", 16'(ofsBUSY), 16'd0);
      nd = 0;
      for (int k = 0; k < 20; k++) begin
         if (ofsDONE) nd++;
         tick();
      end
      check("clr.ndone", 16'(nd),     16'd0);
      check("clr.hold",  16'(ofsPOS), 16'd1);

      run_seq("inject", OFFSET, 16'o000004, 8'd2, 8'd3,  8'd4,  1 + 3*STEP + SETTLE + 1, 1'b0, 1'b1);
      run_seq("equal",  OFFSET, 16'o000004, 8'd4, 8'd4,  8'd4,  1 + SETTLE + 1,          1'b0, 1'b0);
      run_seq("max",    OFFSET, 16'o000012, 8'd5, 8'd6,  8'd10, 1 + 6*STEP + SETTLE + 1, 1'b0, 1'b0);

      // Unsupported function code is ignored.
      go(5'o05, 16'o000003);
      check("badfun.busy", 16'(ofsBUSY), 16'd0);
      check("badfun.pos",  16'(ofsPOS),  16'd10);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
